detach_vb: RTL and testbench
============================

# detach_vb

Receive-side splitter for the merged CB/VB frame stream. It locks onto a frame header, forwards the 50 CB words (header included) to a CB output stream, and buffers the 16 VB words. It checks the trailer; on a good trailer it releases the buffered VB words as a 16-word burst, on a bad trailer it discards them. It sits at the receiving end of the link, downstream of the CB/VB merge stage.

## Interface
- Parameters:
  - HDR, 16'hAAAA, frame header word
  - TRL, 16'h5554, trailer word
  - NCB, 50, CB words per frame, header included
  - NVB, 16, VB words per frame
- Ports:
  - clk  in  1  system clock; all logic on rising edge
  - rst  in  1  reset, synchronous, active-high
  - din  in  16  merged stream; one word per clock, no valid strobe
  - cb_data  out  16  forwarded CB word
  - cb_valid  out  1  cb_data valid
  - cb_first  out  1  high with the header word (CB index 0)
  - vb_data  out  16  buffered VB word
  - vb_valid  out  1  vb_data valid
  - vb_idx  out  4  VB word index, 0..15
  - frame_ok  out  1  one-cycle pulse; trailer matched
  - vb_zero  out  1  with frame_ok; all 16 VB words were 0 (VB absent upstream)
  - trailer_err  out  1  one-cycle pulse; trailer mismatch
  - pad_err  out  1  one-cycle pulse; word after trailer was not 0
  - frame_cnt  out  16  count of frame_ok pulses; wraps
  - err_cnt  out  8  count of trailer_err pulses; saturates at 255

## Operation
- Frame on din, cycle offsets from the header:
  - 0..49: CB words; word 0 is HDR.
  - 50..65: VB words 0..15.
  - 66: TRL.
  - 67: pad word, 16'h0000.
- FSM states: IDLE, CB, VB, TRL, PAD.
  - IDLE: if din==HDR, forward it as CB word 0, set cnt=1, go to CB. Any other word is ignored.
  - CB: forward din, cnt++. After CB word 49 is forwarded, clear cnt and go to VB.
  - VB: write din into buf[cnt] (16x16 register array). OR din into an all-word accumulator. cnt++. After word 15, go to TRL.
  - TRL: compare din to TRL.
    - Match: pulse frame_ok, set vb_zero = ~accumulator, frame_cnt++, start the drain.
    - Mismatch: pulse trailer_err, err_cnt++ (saturating), no drain.
    - Either way go to PAD.
  - PAD: if din!=0, pulse pad_err (status only, frame not cancelled). Go to IDLE.
- A HDR value inside CB/VB/TRL/PAD is treated as data; there is no mid-frame resync.
- Drain: a separate counter outputs buf[0..15] on consecutive cycles, independent of the FSM. The next frame's header can be accepted during a drain. The next frame's VB writes cannot collide with the drain: they begin ≥50 cycles after the header, and the drain finishes first.
- Arithmetic: cnt is 6 bits; drain index is 4 bits; frame_cnt wraps FFFF→0000; err_cnt holds at FF.

## Timing
- All outputs are registered. A word on din in cycle n produces its response in cycle n+1.
- cb_valid is high for exactly 50 consecutive cycles, h+1..h+50, where h is the header cycle. cb_first is high in h+1 only.
- With trailer cycle t=h+66:
  - frame_ok (or trailer_err) and vb_zero appear in t+1.
  - vb_valid is high in t+1..t+16 with vb_idx 0..15.
  - pad_err, if any, appears in t+2.
- Back-to-back frames: a header in cycle h+68 is accepted. Its cb_valid begins at h+69 while the previous drain is still running.
- Reset values: all outputs 0, FSM in IDLE, counters 0.
- Reset mid-frame or mid-drain: the next cycle has all outputs 0 and any partial frame or pending drain is discarded. Buffer contents are don't-care.
- Reset and HDR in the same cycle: reset wins; the header is not accepted.

## Test plan
- Single good frame:
  - Stimulus: HDR, CB 0x0001..0x0031, VB 0x1000..0x100F, TRL, 0.
  - Required: 50 cb_valid cycles matching input; frame_ok at t+1; vb burst 0x1000..0x100F with idx 0..15; frame_cnt=1.
- Bad trailer:
  - Stimulus: same frame with 0x5555 in place of TRL.
  - Required: trailer_err pulse; no vb_valid; err_cnt=1; frame_cnt unchanged.
- VB absent:
  - Stimulus: all 16 VB words = 0.
  - Required: frame_ok and vb_zero together; 16 zero words drained.
- Back-to-back frames:
  - Stimulus: second header immediately after the pad word; a CB word equal to HDR inside frame 1.
  - Required: both frames parsed, cb_first exactly twice, drain overlaps frame 2 CB, frame_cnt=2.
- Reset:
  - Stimulus: rst asserted at CB index 20, then a full frame.
  - Required: outputs 0 the cycle after rst; no frame_ok for the aborted frame; the following frame parses normally.
- Pad and saturation:
  - Stimulus: pad word 0x0001.
  - Required: pad_err at t+2, frame_ok still set.
  - Stimulus: 300 bad-trailer frames.
  - Required: err_cnt=255.

Source files
------------

// File: rtl/detach_vb_if.sv
`default_nettype none
// ============================================================================
// Module   : detach_vb_if
// Brief    : Merged CB/VB input stream plus CB, VB and status outputs
// Revision : 1.0 - initial release
// ============================================================================
interface detach_vb_if;
   logic [15:0] din;
   logic [15:0] cb_data;
   logic        cb_valid;
   logic        cb_first;
   logic [15:0] vb_data;
   logic        vb_valid;
   logic [3:0]  vb_idx;
   logic        frame_ok;
   logic        vb_zero;
   logic        trailer_err;
   logic        pad_err;
   logic [15:0] frame_cnt;
   logic [7:0]  err_cnt;

   // master: stream source / result sink; slave: the splitter itself
   modport master (
      output din,
      input  cb_data, cb_valid, cb_first,
      input  vb_data, vb_valid, vb_idx,
      input  frame_ok, vb_zero, trailer_err, pad_err,
      input  frame_cnt, err_cnt
   );

   modport slave (
      input  din,
      output cb_data, cb_valid, cb_first,
      output vb_data, vb_valid, vb_idx,
      output frame_ok, vb_zero, trailer_err, pad_err,
      output frame_cnt, err_cnt
   );
endinterface
`default_nettype wire

// File: rtl/detach_vb.sv
`default_nettype none
// ============================================================================
// Module   : detach_vb
// Brief    : Splits a merged CB/VB frame stream; forwards CB, drains VB on a
//            good trailer
// Revision : 1.0 - initial release
// ============================================================================
module detach_vb #(
   parameter logic [15:0] HDR = 16'hAAAA,
   parameter logic [15:0] TRL = 16'h5554,
   parameter int          NCB = 50,
   parameter int          NVB = 16
) (
   input  wire logic  clk,
   input  wire logic  rst,
   detach_vb_if.slave bus
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CB   = 3'd1;
   localparam logic [2:0] S_VB   = 3'd2;
   localparam logic [2:0] S_TRL  = 3'd3;
   localparam logic [2:0] S_PAD  = 3'd4;

   localparam logic [5:0] c_CB_LAST = 6'(NCB - 1);
   localparam logic [5:0] c_VB_LAST = 6'(NVB - 1);
   localparam logic [3:0] c_DR_LAST = 4'(NVB - 1);

   logic [2:0]  r_state;
   logic [2:0]  w_next;
   logic [5:0]  r_cnt;
   logic [15:0] r_acc;
   logic [15:0] r_buf [0:NVB-1];
   logic        r_drain_act;
   logic [3:0]  r_drain_ptr;

   logic        w_hdr;
   logic        w_cb_valid;
   logic        w_cb_first;
   logic        w_vb_wr;
   logic        w_trl_ok;
   logic        w_trl_bad;
   logic        w_pad_bad;

   logic [15:0] r_cb_data;
   logic        r_cb_valid;
   logic        r_cb_first;
   logic [15:0] r_vb_data;
   logic        r_vb_valid;
   logic [3:0]  r_vb_idx;
   logic        r_frame_ok;
   logic        r_vb_zero;
   logic        r_trailer_err;
   logic        r_pad_err;
   logic [15:0] r_frame_cnt;
   logic [7:0]  r_err_cnt;

   assign w_hdr = (bus.din == HDR);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_hdr) w_next = S_CB;
         S_CB:    if (r_cnt == c_CB_LAST) w_next = S_VB;
         S_VB:    if (r_cnt == c_VB_LAST) w_next = S_TRL;
         S_TRL:   w_next = S_PAD;
         S_PAD:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Header is only recognised in IDLE; inside a frame it is plain data
   always_comb begin
      w_cb_valid = 1'b0;
      w_cb_first = 1'b0;
      w_vb_wr    = 1'b0;
      w_trl_ok   = 1'b0;
      w_trl_bad  = 1'b0;
      w_pad_bad  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cb_valid = w_hdr;
            w_cb_first = w_hdr;
         end
         S_CB:  w_cb_valid = 1'b1;
         S_VB:  w_vb_wr    = 1'b1;
         S_TRL: begin
            w_trl_ok  = (bus.din == TRL);
            w_trl_bad = (bus.din != TRL);
         end
         S_PAD:   w_pad_bad = (bus.din != 16'h0000);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= 6'd0;
      end else begin
         case (r_state)
            S_IDLE:  r_cnt <= w_hdr ? 6'd1 : 6'd0;
            S_CB:    r_cnt <= (r_cnt == c_CB_LAST) ? 6'd0 : r_cnt + 6'd1;
            S_VB:    r_cnt <= r_cnt + 6'd1;
            default: r_cnt <= 6'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || (r_state == S_IDLE && w_hdr)) begin
         r_acc <= 16'h0000;
      end else if (w_vb_wr) begin
         r_acc <= r_acc | bus.din;
      end
   end

   // Buffer holds no reset; its contents are don't-care until written
   always_ff @(posedge clk) begin
      if (w_vb_wr) begin
         r_buf[r_cnt[3:0]] <= bus.din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cb_data     <= 16'h0000;
         r_cb_valid    <= 1'b0;
         r_cb_first    <= 1'b0;
         r_frame_ok    <= 1'b0;
         r_vb_zero     <= 1'b0;
         r_trailer_err <= 1'b0;
         r_pad_err     <= 1'b0;
         r_frame_cnt   <= 16'h0000;
         r_err_cnt     <= 8'h00;
      end else begin
         r_cb_data     <= w_cb_valid ? bus.din : 16'h0000;
         r_cb_valid    <= w_cb_valid;
         r_cb_first    <= w_cb_first;
         r_frame_ok    <= w_trl_ok;
         r_vb_zero     <= w_trl_ok & ~|r_acc;
         r_trailer_err <= w_trl_bad;
         r_pad_err     <= w_pad_bad;
         if (w_trl_ok) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_trl_bad && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   // Drain runs on its own so the next frame's CB phase can overlap it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_drain_act <= 1'b0;
         r_drain_ptr <= 4'd0;
         r_vb_valid  <= 1'b0;
         r_vb_data   <= 16'h0000;
         r_vb_idx    <= 4'd0;
      end else if (w_trl_ok) begin
         r_drain_act <= 1'b1;
         r_drain_ptr <= 4'd1;
         r_vb_valid  <= 1'b1;
         r_vb_data   <= r_buf[0];
         r_vb_idx    <= 4'd0;
      end else if (r_drain_act) begin
         r_drain_ptr <= r_drain_ptr + 4'd1;
         r_vb_valid  <= 1'b1;
         r_vb_data   <= r_buf[r_drain_ptr];
         r_vb_idx    <= r_drain_ptr;
         if (r_drain_ptr == c_DR_LAST) begin
            r_drain_act <= 1'b0;
         end
      end else begin
         r_vb_valid <= 1'b0;
         r_vb_data  <= 16'h0000;
         r_vb_idx   <= 4'd0;
      end
   end

   assign bus.cb_data     = r_cb_data;
   assign bus.cb_valid    = r_cb_valid;
   assign bus.cb_first    = r_cb_first;
   assign bus.vb_data     = r_vb_data;
   assign bus.vb_valid    = r_vb_valid;
   assign bus.vb_idx      = r_vb_idx;
   assign bus.frame_ok    = r_frame_ok;
   assign bus.vb_zero     = r_vb_zero;
   assign bus.trailer_err = r_trailer_err;
   assign bus.pad_err     = r_pad_err;
   assign bus.frame_cnt   = r_frame_cnt;
   assign bus.err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_detach_vb.sv
`default_nettype none
// ============================================================================
// Module   : tb_detach_vb
// Brief    : Scoreboard bench for detach_vb with a frame-level reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_detach_vb;
   localparam logic [15:0] HDR = 16'hAAAA;
   localparam logic [15:0] TRL = 16'h5554;

   typedef struct {int cyc; logic [15:0] d; logic first;} cb_t;
   typedef struct {int cyc; logic [15:0] d; logic [3:0] idx;} vb_t;
   // flags = {frame_ok, vb_zero, trailer_err, pad_err}
   typedef struct {int cyc; logic [3:0] flags; logic [15:0] fcnt; logic [7:0] ecnt;} ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   m_f = 0;
   int   m_e = 0;

   cb_t cbq[$];
   vb_t vbq[$];
   ev_t evq[$];
   logic [15:0] fr [0:67];

   detach_vb_if bus();

   detach_vb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic flag(input string nm, input string what);
      n_cmp++;
      n_err++;
      $display("FAIL %s @cyc %0d: %s", nm, cyc, what);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_ctl"}, 64'({bus.cb_valid, bus.cb_first, bus.vb_valid, bus.vb_idx,
                             bus.frame_ok, bus.vb_zero, bus.trailer_err, bus.pad_err,
                             bus.frame_cnt, bus.err_cnt}), 64'd0);
      chk({nm, "_data"}, 64'({bus.cb_data, bus.vb_data}), 64'd0);
   endtask

   task automatic drive(input logic [15:0] w, input logic r);
      bus.din = w;
      rst     = r;
      @(posedge clk);
      #1;
   endtask

   // Idle filler never equals HDR (top bit clear)
   task automatic gap(input int n);
      for (int i = 0; i < n; i++) drive(16'($urandom) & 16'h7FFF, 1'b0);
   endtask

   task automatic base_frame();
      fr[0] = HDR;
      for (int i = 1; i < 50; i++) fr[i] = 16'(i);
      for (int k = 0; k < 16; k++) fr[50+k] = 16'h1000 + 16'(k);
      fr[66] = TRL;
      fr[67] = 16'h0000;
   endtask

   task automatic rand_frame();
      logic [15:0] bad;
      bit vbz;
      fr[0] = HDR;
      for (int i = 1; i < 50; i++) fr[i] = ($urandom_range(7) == 0) ? HDR : 16'($urandom);
      vbz = ($urandom_range(3) == 0);
      for (int k = 0; k < 16; k++) fr[50+k] = vbz ? 16'h0000 : 16'($urandom);
      bad = 16'($urandom);
      if (bad == TRL) bad = bad ^ 16'h0001;
      fr[66] = ($urandom_range(3) == 0) ? bad : TRL;
      fr[67] = ($urandom_range(5) == 0) ? 16'($urandom_range(65535, 1)) : 16'h0000;
   endtask

   // Expected responses follow directly from word offsets within the frame;
   // rst_at >= 0 asserts reset at that offset and drops anything after it
   task automatic send_frame(input int rst_at);
      int h, t, lim;
      logic [15:0] acc;
      h   = cyc;
      t   = h + 66;
      lim = (rst_at >= 0) ? h + rst_at : 32'h7FFF_FFFF;
      acc = 16'h0000;
      for (int k = 0; k < 16; k++) acc = acc | fr[50+k];
      for (int i = 0; i < 50; i++)
         if (h + 1 + i <= lim) cbq.push_back('{h + 1 + i, fr[i], (i == 0)});
      if (t + 1 <= lim) begin
         if (fr[66] == TRL) begin
            m_f = (m_f + 1) % 65536;
            evq.push_back('{t + 1, {1'b1, (acc == 16'h0000), 2'b00}, 16'(m_f), 8'(m_e)});
            for (int k = 0; k < 16; k++)
               if (t + 1 + k <= lim) vbq.push_back('{t + 1 + k, fr[50+k], 4'(k)});
         end else begin
            if (m_e < 255) m_e++;
            evq.push_back('{t + 1, 4'b0010, 16'(m_f), 8'(m_e)});
         end
      end
      if (fr[67] != 16'h0000 && t + 2 <= lim)
         evq.push_back('{t + 2, 4'b0001, 16'(m_f), 8'(m_e)});
      for (int i = 0; i < 68 && (rst_at < 0 || i <= rst_at); i++) drive(fr[i], (i == rst_at));
      for (int i = 68; i <= rst_at; i++) drive(16'h0000, (i == rst_at));
      if (rst_at >= 0) begin
         m_f = 0;
         m_e = 0;
         chk_zero("rst_midframe");
      end
   endtask

   always @(negedge clk) begin
      cb_t c;
      vb_t v;
      ev_t e;
      while (cbq.size() > 0 && cbq[0].cyc < cyc) begin
         c = cbq.pop_front();
         flag("cb_missing", $sformatf("no cb_valid for word 0x%0h due at cyc %0d", c.d, c.cyc));
      end
      while (vbq.size() > 0 && vbq[0].cyc < cyc) begin
         v = vbq.pop_front();
         flag("vb_missing", $sformatf("no vb_valid for idx %0d due at cyc %0d", v.idx, v.cyc));
      end
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
         e = evq.pop_front();
         flag("ev_missing", $sformatf("flags %b due at cyc %0d not seen", e.flags, e.cyc));
      end
      if (bus.cb_valid) begin
         if (cbq.size() == 0 || cbq[0].cyc != cyc) begin
            flag("cb_unexpected", $sformatf("cb_valid with data 0x%0h", bus.cb_data));
         end else begin
            c = cbq.pop_front();
            chk("cb_data", 64'(bus.cb_data), 64'(c.d));
            chk("cb_first", 64'(bus.cb_first), 64'(c.first));
         end
      end else if (bus.cb_first) begin
         flag("cb_first_alone", "cb_first without cb_valid");
      end
      if (bus.vb_valid) begin
         if (vbq.size() == 0 || vbq[0].cyc != cyc) begin
            flag("vb_unexpected", $sformatf("vb_valid idx %0d data 0x%0h", bus.vb_idx, bus.vb_data));
         end else begin
            v = vbq.pop_front();
            chk("vb_data", 64'(bus.vb_data), 64'(v.d));
            chk("vb_idx", 64'(bus.vb_idx), 64'(v.idx));
         end
      end
      if (bus.frame_ok | bus.vb_zero | bus.trailer_err | bus.pad_err) begin
         if (evq.size() == 0 || evq[0].cyc != cyc) begin
            flag("ev_unexpected", $sformatf("flags %b", {bus.frame_ok, bus.vb_zero,
                                                          bus.trailer_err, bus.pad_err}));
         end else begin
            e = evq.pop_front();
            chk("ev_flags", 64'({bus.frame_ok, bus.vb_zero, bus.trailer_err, bus.pad_err}),
                64'(e.flags));
            chk("frame_cnt", 64'(bus.frame_cnt), 64'(e.fcnt));
            chk("err_cnt", 64'(bus.err_cnt), 64'(e.ecnt));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.din = 16'h0000;
      rst     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");

      base_frame();
      send_frame(-1);
      gap(2);

      base_frame();
      fr[66] = 16'h5555;
      send_frame(-1);
      gap(2);

      base_frame();
      for (int k = 0; k < 16; k++) fr[50+k] = 16'h0000;
      send_frame(-1);
      gap(1);

      base_frame();
      fr[7] = HDR;
      send_frame(-1);
      base_frame();
      send_frame(-1);
      gap(20);
      chk("frame_cnt_b2b", 64'(bus.frame_cnt), 64'(m_f));

      base_frame();
      send_frame(20);
      base_frame();
      send_frame(-1);
      gap(2);

      base_frame();
      send_frame(70);
      gap(3);

      drive(HDR, 1'b1);
      chk_zero("rst_with_hdr");
      m_f = 0;
      m_e = 0;
      gap(5);

      base_frame();
      fr[67] = 16'h0001;
      send_frame(-1);
      gap(1);

      repeat (40) begin
         rand_frame();
         send_frame(-1);
         gap($urandom_range(2));
      end

      repeat (300) begin
         base_frame();
         fr[66] = 16'h5555;
         send_frame(-1);
      end
      gap(20);

      chk("err_cnt_sat", 64'(bus.err_cnt), 64'd255);
      chk("frame_cnt_final", 64'(bus.frame_cnt), 64'(m_f));
      chk("cb_left", 64'(cbq.size()), 64'd0);
      chk("vb_left", 64'(vbq.size()), 64'd0);
      chk("ev_left", 64'(evq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
